// File: rtl/memory_stage.sv
// memory_stage: RV32 MEM stage, MEM/WB register and writeback mux, with a latency-stalled data RAM.
// Optional build macro MEM_STAGE_ALIGN_CHECK_EN adds MisalignW and suppresses misaligned accesses.
module memory_stage #(
    parameter int DEPTH       = 256,
    parameter int MEM_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemWriteM,
    input  logic        ResultSrcM,
    input  logic [4:0]  RD_M,
    input  logic [31:0] PCPlus4M,
    input  logic [31:0] WriteDataM,
    input  logic [31:0] ALU_ResultM,
    output logic        StallM,
    output logic        RegWriteW,
    output logic [4:0]  RD_W,
    output logic        ResultSrcW,
    output logic [31:0] ALU_ResultW,
    output logic [31:0] ReadDataW,
    output logic [31:0] PCPlus4W,
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    output logic        MisalignW,
`endif
    output logic [31:0] ResultW
);

    // state  | meaning
    // S_IDLE | nothing outstanding; non-access and zero-latency accesses commit here
    // S_WAIT | load/store in flight; commits on the cycle cnt reaches 0

    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_INIT = (MEM_LATENCY > 0) ? 4'(MEM_LATENCY - 1) : 4'd0;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state, state_next;
    logic [3:0]  cnt, cnt_next;
    logic        access;
    logic        ready;
    logic        misalign;
    logic [AW-1:0] index;
    logic [31:0] rd_data;
    logic [31:0] mem [DEPTH];
    logic        unused_addr_bits;

    assign access = MemWriteM | ResultSrcM;
    assign index  = ALU_ResultM[AW+1:2];
    assign rd_data = mem[index];
    assign unused_addr_bits = ^{ALU_ResultM[31:AW+2], ALU_ResultM[1:0]};

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    assign misalign = access && (ALU_ResultM[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            S_IDLE: begin
                if (access && (MEM_LATENCY > 0)) begin
                    state_next = S_WAIT;
                    cnt_next   = LAT_INIT;
                end
            end
            S_WAIT: begin
                if (cnt != 4'd0) begin
                    cnt_next = cnt - 4'd1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
                cnt_next   = 4'd0;
            end
        endcase
    end

    always_comb begin
        ready  = !access || (MEM_LATENCY == 0) || (state == S_WAIT && cnt == 4'd0);
        StallM = !ready;
    end

    // RAM is never reset; a store lands only on its commit edge
    always_ff @(posedge clk) begin
        if (ready && MemWriteM && !misalign) begin
            mem[index] <= WriteDataM;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteW   <= 1'b0;
            RD_W        <= 5'd0;
            ResultSrcW  <= 1'b0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            PCPlus4W    <= 32'd0;
        end else if (ready) begin
            RegWriteW   <= RegWriteM;
            RD_W        <= RD_M;
            ResultSrcW  <= ResultSrcM;
            ALU_ResultW <= ALU_ResultM;
            ReadDataW   <= misalign ? 32'd0 : rd_data;
            PCPlus4W    <= PCPlus4M;
        end else begin
            RegWriteW   <= 1'b0;
            RD_W        <= 5'd0;
            ResultSrcW  <= 1'b0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            PCPlus4W    <= 32'd0;
        end
    end

`ifdef MEM_STAGE_ALIGN_CHECK_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            MisalignW <= 1'b0;
        end else begin
            MisalignW <= ready && misalign;
        end
    end
`endif

    assign ResultW = ResultSrcW ? ReadDataW : ALU_ResultW;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: two instances (latency 2 and latency 0) driven by directed and random
// instructions, checked against a transaction-level model of the stage.
`timescale 1ns/1ps
module tb_memory_stage;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        logic        result_src;
        logic [4:0]  rd;
        logic [31:0] pc4;
        logic [31:0] wdata;
        logic [31:0] addr;
    } instr_t;

    typedef struct packed {
        logic        reg_write;
        logic [4:0]  rd;
        logic        result_src;
        logic        misalign;
        logic [31:0] alu;
        logic [31:0] pc4;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst;
    instr_t in_a, in_b;
    logic stall_a, stall_b;
    logic rw_a, rw_b, rs_a, rs_b, mis_a, mis_b;
    logic [4:0] rd_a, rd_b;
    logic [31:0] alu_a, alu_b, rdata_a, rdata_b, pc4_a, pc4_b, res_a, res_b;

    int vectors = 0;
    int miscompares = 0;
    logic [31:0] ref_mem [2][256];
    bit known [2][256];

    always #5 clk = ~clk;

    memory_stage #(.DEPTH(256), .MEM_LATENCY(2)) u_dut (
        .clk(clk), .rst(rst),
        .RegWriteM(in_a.reg_write), .MemWriteM(in_a.mem_write), .ResultSrcM(in_a.result_src),
        .RD_M(in_a.rd), .PCPlus4M(in_a.pc4), .WriteDataM(in_a.wdata), .ALU_ResultM(in_a.addr),
        .StallM(stall_a), .RegWriteW(rw_a), .RD_W(rd_a), .ResultSrcW(rs_a),
        .ALU_ResultW(alu_a), .ReadDataW(rdata_a), .PCPlus4W(pc4_a),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        .MisalignW(mis_a),
`endif
        .ResultW(res_a)
    );

    memory_stage #(.DEPTH(256), .MEM_LATENCY(0)) u_dut0 (
        .clk(clk), .rst(rst),
        .RegWriteM(in_b.reg_write), .MemWriteM(in_b.mem_write), .ResultSrcM(in_b.result_src),
        .RD_M(in_b.rd), .PCPlus4M(in_b.pc4), .WriteDataM(in_b.wdata), .ALU_ResultM(in_b.addr),
        .StallM(stall_b), .RegWriteW(rw_b), .RD_W(rd_b), .ResultSrcW(rs_b),
        .ALU_ResultW(alu_b), .ReadDataW(rdata_b), .PCPlus4W(pc4_b),
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        .MisalignW(mis_b),
`endif
        .ResultW(res_b)
    );

`ifndef MEM_STAGE_ALIGN_CHECK_EN
    assign mis_a = 1'b0;
    assign mis_b = 1'b0;
`endif

    function automatic ctrl_t get_ctrl(input int sel);
        ctrl_t c;
        if (sel != 0) c = {rw_b, rd_b, rs_b, mis_b, alu_b, pc4_b};
        else          c = {rw_a, rd_a, rs_a, mis_a, alu_a, pc4_a};
        return c;
    endfunction

    // Model: an access costs `latency` stall cycles then commits; result fields follow the
    // instruction, load data is the model memory word before any store in the same instruction.
    task automatic apply(input int sel, input instr_t t);
        int lat, idx;
        bit acc, mis, rd_known;
        logic st;
        ctrl_t exp_c, got_c;
        logic [31:0] exp_rd, exp_res, got_rd, got_res;
        acc = t.mem_write | t.result_src;
        idx = (t.addr / 4) % 256;
`ifdef MEM_STAGE_ALIGN_CHECK_EN
        mis = acc && (t.addr % 4 != 0);
`else
        mis = 1'b0;
`endif
        lat = (acc && sel == 0) ? 2 : 0;
        if (sel != 0) in_b = t; else in_a = t;
        for (int c = 0; c <= lat; c++) begin
            @(negedge clk);
            st = (sel != 0) ? stall_b : stall_a;
            vectors++;
            if (st !== (c < lat)) begin
                miscompares++;
                $display("FAIL stall dut%0d cycle %0d: got %b want %b", sel, c, st, (c < lat));
            end
            if (c > 0) begin
                got_c   = get_ctrl(sel);
                got_res = (sel != 0) ? res_b : res_a;
                vectors++;
                if (got_c !== '0 || got_res !== 32'd0) begin
                    miscompares++;
                    $display("FAIL bubble dut%0d cycle %0d: got ctrl %h result %h want 0", sel, c, got_c, got_res);
                end
            end
            @(posedge clk);
            #1;
        end
        exp_c.reg_write  = t.reg_write;
        exp_c.rd         = t.rd;
        exp_c.result_src = t.result_src;
        exp_c.misalign   = mis;
        exp_c.alu        = t.addr;
        exp_c.pc4        = t.pc4;
        rd_known = mis || known[sel][idx];
        exp_rd   = mis ? 32'd0 : ref_mem[sel][idx];
        exp_res  = t.result_src ? exp_rd : t.addr;
        got_c    = get_ctrl(sel);
        got_rd   = (sel != 0) ? rdata_b : rdata_a;
        got_res  = (sel != 0) ? res_b : res_a;
        vectors++;
        if (got_c !== exp_c) begin
            miscompares++;
            $display("FAIL wctrl dut%0d addr %h: got %h want %h", sel, t.addr, got_c, exp_c);
        end
        if (rd_known) begin
            vectors++;
            if (got_rd !== exp_rd) begin
                miscompares++;
                $display("FAIL readdata dut%0d addr %h: got %h want %h", sel, t.addr, got_rd, exp_rd);
            end
        end
        if (rd_known || !t.result_src) begin
            vectors++;
            if (got_res !== exp_res) begin
                miscompares++;
                $display("FAIL resultw dut%0d addr %h: got %h want %h", sel, t.addr, got_res, exp_res);
            end
        end
        if (t.mem_write && !mis) begin
            ref_mem[sel][idx] = t.wdata;
            known[sel][idx]   = 1'b1;
        end
        if (sel != 0) in_b = '0; else in_a = '0;
    endtask

    function automatic instr_t mk(input bit rw, input bit mw, input bit rs, input logic [4:0] rd,
                                  input logic [31:0] addr, input logic [31:0] wdata);
        instr_t t;
        t.reg_write = rw; t.mem_write = mw; t.result_src = rs; t.rd = rd;
        t.addr = addr; t.wdata = wdata; t.pc4 = $urandom;
        return t;
    endfunction

    task automatic check_zero(input string name);
        ctrl_t ca, cb;
        ca = get_ctrl(0);
        cb = get_ctrl(1);
        vectors++;
        if (ca !== '0 || cb !== '0 || rdata_a !== 32'd0 || rdata_b !== 32'd0 ||
            res_a !== 32'd0 || res_b !== 32'd0) begin
            miscompares++;
            $display("FAIL %s: got ctrl %h/%h rdata %h/%h result %h/%h want all 0",
                     name, ca, cb, rdata_a, rdata_b, res_a, res_b);
        end
    endtask

    task automatic test_reset();
        #3;
        check_zero("reset_outputs");
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 256; i++) begin
            apply(0, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'(i * 4), $urandom));
            apply(1, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'(i * 4), $urandom));
        end
    endtask

    task automatic test_store_load();
        apply(0, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h20, 32'hDEADBEEF));
        apply(0, mk(1'b1, 1'b0, 1'b1, 5'd5, 32'h20, 32'h0));
    endtask

    task automatic test_alu();
        apply(0, mk(1'b1, 1'b0, 1'b0, 5'd9, 32'h1234, 32'hFFFF_0000));
        apply(1, mk(1'b1, 1'b0, 1'b0, 5'd3, 32'h1234, 32'h0));
    endtask

    task automatic test_lat0();
        apply(1, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h40, 32'hCAFE_F00D));
        apply(1, mk(1'b1, 1'b0, 1'b1, 5'd7, 32'h40, 32'h0));
    endtask

    task automatic test_alias();
        apply(0, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h400, 32'h55));
        apply(0, mk(1'b1, 1'b0, 1'b1, 5'd1, 32'h0, 32'h0));
    endtask

    task automatic test_low_bits();
        apply(0, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h22, 32'h7));
        apply(0, mk(1'b1, 1'b0, 1'b1, 5'd2, 32'h22, 32'h0));
        apply(0, mk(1'b1, 1'b0, 1'b1, 5'd2, 32'h20, 32'h0));
        apply(1, mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h23, 32'h7));
        apply(1, mk(1'b1, 1'b0, 1'b1, 5'd2, 32'h20, 32'h0));
    endtask

    task automatic test_mid_reset();
        instr_t t;
        t = mk(1'b0, 1'b1, 1'b0, 5'd0, 32'h10, ~ref_mem[0][4]);
        in_a = t;
        in_b = mk(1'b1, 1'b0, 1'b0, 5'd4, 32'h1234, 32'h0);
        @(negedge clk);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("midreset_outputs");
        in_a = '0;
        in_b = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (stall_a !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_stall: got %b want 0", stall_a);
        end
        @(posedge clk);
        #1;
        apply(0, mk(1'b1, 1'b0, 1'b1, 5'd6, 32'h10, 32'h0));
    endtask

    task automatic test_back_to_back();
        instr_t t;
        for (int n = 0; n < 300; n++) begin
            t = mk($urandom_range(0, 1) != 0, 1'b0, 1'b0, 5'($urandom), $urandom, $urandom);
            case ($urandom_range(0, 2))
                0: ;
                1: t.result_src = 1'b1;
                default: t.mem_write = 1'b1;
            endcase
            if ($urandom_range(0, 3) != 0) t.addr[1:0] = 2'b00;
            apply(n % 2, t);
        end
    endtask

    initial begin
        rst  = 1'b0;
        in_a = '0;
        in_b = '0;
        test_reset();
        test_fill();
        test_store_load();
        test_alu();
        test_lat0();
        test_alias();
        test_low_bits();
        test_mid_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
